irq_timer: RTL
==============

Name: irq_timer

Overview:
- Memory-mapped timer peripheral on the CPU bus, selected by the address decoder's timer chip-select (I/O bank 5, window $FE00-$FEFF).
- Provides a free-running 32-bit millisecond uptime counter.
- Provides a 16-bit programmable countdown with one-shot and auto-reload modes, a sticky expiry flag and an active-low IRQ.
- Read data is combinational and feeds the top-level read-data mux; writes are synchronous.

Parameters:
- CLK_FREQ_HZ, 27000000, system clock frequency.
- TICK_HZ, 1000, tick rate. DIV = CLK_FREQ_HZ/TICK_HZ must be an integer >= 2.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- cs_i  in  1  chip select from address decoder
- r_w_n_i  in  1  CPU read(1)/write(0)
- addr_i  in  8  low address byte (register offset)
- data_i  in  8  CPU write data
- data_o  out  8  read data; 0 when cs_i=0 or offset unmapped
- irq_n_o  out  1  interrupt request, active-low

Behaviour:
- Reset: all registers, prescaler, snapshots and flags clear to 0; data_o=0; irq_n_o=1.
- Write: performed at every rising clk_i edge with cs_i=1 and r_w_n_i=0. Writes are idempotent if held for several cycles.
- Register map (offset, access):
  - $00 CTRL (RW): bit0 EN, bit1 AUTO, bit2 IE; bits 7:3 read 0.
  - $01 STATUS: bit0 EXP (sticky; write 1 clears), bit1 RUN (read-only).
  - $02/$03 RELOAD_L/H (RW).
  - $04/$05 COUNT_L/H (RO): reading $04 latches COUNT[15:8] into a snapshot; $05 returns the snapshot.
  - $06-$09 UPTIME byte0-3 (RO): reading $06 latches bytes 1-3; $07-$09 return the snapshot.
  - $0A START (WO): any write loads COUNT<=RELOAD and sets RUN=1.
  - All other offsets read 0; writes to them are ignored.
- Snapshot latch timing: the latch occurs at each clk edge with cs_i=1, r_w_n_i=1 and the matching offset. The latched byte-0 path itself is combinational from the live counter.
- Prescaler: free-running 0..DIV-1 and never reset by START. tick=1 for exactly one cycle when the prescaler equals DIV-1.
- Uptime: +1 on each tick, wraps $FFFFFFFF->0.
- Countdown, evaluated on a tick when EN=1 and RUN=1:
  - COUNT>1: COUNT-1.
  - COUNT<=1: EXP<=1. If AUTO=1, COUNT<=RELOAD and RUN stays 1; else COUNT<=0 and RUN<=0.
- EN=0 freezes COUNT and RUN. RELOAD=0 with START expires on the next qualifying tick.
- Simultaneous events:
  - START and tick in the same cycle: START wins, no decrement.
  - EXP clear and expiry in the same cycle: set wins.
  - CTRL write and tick in the same cycle: the tick uses the old CTRL.
- irq_n_o = ~(EXP & IE), derived only from registers (glitch-free).
- Reset asserted mid-count: immediate return to reset values; the timer does not resume afterwards.

Decomposition:
- Shared package holds register offset constants ($00-$0A), CTRL/STATUS bit indices and the reset value of each register.
- One sub-module, tick_prescaler (parameter DIV; ports clk_i, rst_n_i, tick_o).
- Register file, countdown and snapshot logic stay in irq_timer.

Test Plan (CLK_FREQ_HZ=10, TICK_HZ=1, so DIV=10):
- Reset, then read $00-$0A -> all 0, irq_n_o=1; after 35 clocks read $06 -> 3 and $07-$09 -> 0.
- One-shot: RELOAD=$0003, CTRL=$05, START -> EXP=1 and irq_n_o=0 on the 3rd tick after START; RUN=0; COUNT=0; no further EXP after clear.
- Auto-reload: RELOAD=2, CTRL=$07, START -> EXP set every 2 ticks. Writing STATUS=$01 in the same cycle as an expiry leaves EXP=1.
- Snapshot: preset uptime to $000000FF, tick pending. Read $06 (returns $FF), tick rolls to $100, then read $07 -> $00 (snapshot, not $01).
- Freeze and edges: EN=0 mid-count holds COUNT for 50 clocks. START on the tick cycle -> COUNT=RELOAD, no decrement. RELOAD=0 with START -> EXP on the next tick. Unmapped $0B reads 0.
- Reset mid-countdown (COUNT=5, RUN=1) -> all registers 0 and irq_n_o=1 immediately; after release, no EXP for 100 clocks.

Source files
------------

// File: rtl/irq_timer_pkg.sv
// ============================================================================
// irq_timer_pkg : register offsets, bit indices and reset values for irq_timer
// Rev 1.0
// ============================================================================
`default_nettype none

package irq_timer_pkg;

    typedef enum logic [7:0] {
        REG_CTRL     = 8'h00,
        REG_STATUS   = 8'h01,
        REG_RELOAD_L = 8'h02,
        REG_RELOAD_H = 8'h03,
        REG_COUNT_L  = 8'h04,
        REG_COUNT_H  = 8'h05,
        REG_UPTIME0  = 8'h06,
        REG_UPTIME1  = 8'h07,
        REG_UPTIME2  = 8'h08,
        REG_UPTIME3  = 8'h09,
        REG_START    = 8'h0A
    } reg_ofs_e;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_EXP  = 0;
    localparam int STAT_RUN  = 1;

    localparam logic [2:0]  CTRL_RST     = 3'b000;
    localparam logic        EXP_RST      = 1'b0;
    localparam logic        RUN_RST      = 1'b0;
    localparam logic [15:0] RELOAD_RST   = 16'h0000;
    localparam logic [15:0] COUNT_RST    = 16'h0000;
    localparam logic [7:0]  CNT_SNAP_RST = 8'h00;
    localparam logic [31:0] UPTIME_RST   = 32'h0000_0000;
    localparam logic [23:0] UP_SNAP_RST  = 24'h00_0000;

endpackage

`default_nettype wire

// File: rtl/irq_timer_tick_prescaler.sv
// ============================================================================
// tick_prescaler : free-running 0..DIV-1 divider, one-cycle tick at DIV-1
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int DIV = 27000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);

    localparam int          W    = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_timer.sv
// ============================================================================
// irq_timer : bus-mapped uptime counter and 16-bit countdown with active-low IRQ
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_timer
    import irq_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int TICK_HZ     = 1000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cs_i,
    input  logic       r_w_n_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq_n_o
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    logic        tick;
    logic        wr;
    logic        rd;

    logic [2:0]  ctrl_q,     ctrl_d;
    logic        exp_q,      exp_d;
    logic        run_q,      run_d;
    logic [15:0] reload_q,   reload_d;
    logic [15:0] count_q,    count_d;
    logic [7:0]  cnt_snap_q, cnt_snap_d;
    logic [31:0] up_q,       up_d;
    logic [23:0] up_snap_q,  up_snap_d;

    tick_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .tick_o (tick)
    );

    assign wr = cs_i & ~r_w_n_i;
    assign rd = cs_i &  r_w_n_i;

    always_comb begin
        ctrl_d     = ctrl_q;
        exp_d      = exp_q;
        run_d      = run_q;
        reload_d   = reload_q;
        count_d    = count_q;
        cnt_snap_d = cnt_snap_q;
        up_d       = tick ? up_q + 32'd1 : up_q;
        up_snap_d  = up_snap_q;

        if (wr && addr_i == REG_CTRL)     ctrl_d          = data_i[2:0];
        if (wr && addr_i == REG_RELOAD_L) reload_d[7:0]   = data_i;
        if (wr && addr_i == REG_RELOAD_H) reload_d[15:8]  = data_i;
        if (wr && addr_i == REG_STATUS && data_i[STAT_EXP]) exp_d = 1'b0;

        if (rd && addr_i == REG_COUNT_L)  cnt_snap_d = count_q[15:8];
        if (rd && addr_i == REG_UPTIME0)  up_snap_d  = up_q[31:8];

        // START outranks a coincident tick; an expiry outranks a coincident EXP clear.
        if (wr && addr_i == REG_START) begin
            count_d = reload_q;
            run_d   = 1'b1;
        end else if (tick && ctrl_q[CTRL_EN] && run_q) begin
            if (count_q > 16'd1) begin
                count_d = count_q - 16'd1;
            end else begin
                exp_d = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = reload_q;
                end else begin
                    count_d = 16'd0;
                    run_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q     <= CTRL_RST;
            exp_q      <= EXP_RST;
            run_q      <= RUN_RST;
            reload_q   <= RELOAD_RST;
            count_q    <= COUNT_RST;
            cnt_snap_q <= CNT_SNAP_RST;
            up_q       <= UPTIME_RST;
            up_snap_q  <= UP_SNAP_RST;
        end else begin
            ctrl_q     <= ctrl_d;
            exp_q      <= exp_d;
            run_q      <= run_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            cnt_snap_q <= cnt_snap_d;
            up_q       <= up_d;
            up_snap_q  <= up_snap_d;
        end
    end

    always_comb begin
        data_o = 8'h00;
        if (cs_i) begin
            case (addr_i)
                REG_CTRL:     data_o = {5'b00000, ctrl_q};
                REG_STATUS: begin
                    data_o[STAT_EXP] = exp_q;
                    data_o[STAT_RUN] = run_q;
                end
                REG_RELOAD_L: data_o = reload_q[7:0];
                REG_RELOAD_H: data_o = reload_q[15:8];
                REG_COUNT_L:  data_o = count_q[7:0];
                REG_COUNT_H:  data_o = cnt_snap_q;
                REG_UPTIME0:  data_o = up_q[7:0];
                REG_UPTIME1:  data_o = up_snap_q[7:0];
                REG_UPTIME2:  data_o = up_snap_q[15:8];
                REG_UPTIME3:  data_o = up_snap_q[23:16];
                default:      data_o = 8'h00;
            endcase
        end
    end

    assign irq_n_o = ~(exp_q & ctrl_q[CTRL_IE]);

endmodule

`default_nettype wire
